// File: rtl/sdff_bank_pkg.sv
// Shared mode decode and limits for the mux-scan flop bank.
// Mode encodings are one-hot-ish, so an unknown SE/EN decodes to a non-matching value.
package sdff_bank_pkg;

   localparam int SEG_LEN_MAX = 256;

   typedef enum logic [1:0] {
      MODE_HOLD    = 2'b00,
      MODE_CAPTURE = 2'b01,
      MODE_SHIFT   = 2'b10
   } sdff_mode_e;

   // Shift beats capture beats hold; an X select merges the encodings into an illegal code.
   function automatic sdff_mode_e sdff_mode(input logic se, input logic en);
      return se ? MODE_SHIFT : (en ? MODE_CAPTURE : MODE_HOLD);
   endfunction

endpackage

// File: rtl/sdff_scan_seg.sv
// One L-bit mux-scan segment: shifts SI into bit 0 towards bit L-1, which drives SO.
// Any mode code other than the three legal ones loads X rather than silently holding.
module sdff_scan_seg
   import sdff_bank_pkg::*;
#(
   parameter int           L         = 8,
   parameter logic [L-1:0] RESET_VAL = '0
) (
   input  logic         CLK,
   input  logic         RN,
   input  sdff_mode_e   mode,
   input  logic [L-1:0] d,
   input  logic         si,
   output logic         so,
   output logic [L-1:0] q
);

   logic [L:0] shifted;

   // Works for L == 1 as well: the low L bits of {q, si} are the shifted segment.
   assign shifted = {q, si};

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         q <= RESET_VAL;
      end else begin
         case (mode)
            MODE_HOLD:    q <= q;
            MODE_CAPTURE: q <= d;
            MODE_SHIFT:   q <= shifted[L-1:0];
            default:      q <= 'x;
         endcase
      end
   end

   assign so = q[L-1];

endmodule

// File: rtl/sdff_scan_bank.sv
// Bank of mux-scan flops split into CHAINS segments, with shift counter and optional shadow.
// Q and SO update one edge after sampling; SO comes straight from a flop.
module sdff_scan_bank
   import sdff_bank_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               CHAINS    = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               SHADOW    = 1
) (
   input  logic                                CLK,
   input  logic                                RN,
   input  logic                                SE,
   input  logic                                EN,
   input  logic [WIDTH-1:0]                    D,
   input  logic [CHAINS-1:0]                   SI,
   input  logic                                UPD,
   output logic [WIDTH-1:0]                    Q,
   output logic [CHAINS-1:0]                   SO,
   output logic [WIDTH-1:0]                    QS,
   output logic [$clog2(WIDTH/CHAINS+1)-1:0]   SHIFT_CNT,
   output logic                                SHIFT_DONE
);

   localparam int L  = WIDTH / CHAINS;
   localparam int CW = $clog2(L + 1);
   localparam logic [CW-1:0] L_CNT = CW'(L);

   if ((WIDTH % CHAINS) != 0 || L > SEG_LEN_MAX) begin : g_bad_params
      $error("sdff_scan_bank: WIDTH must split evenly into CHAINS segments of at most SEG_LEN_MAX bits");
   end

   sdff_mode_e    mode;
   logic [CW-1:0] cnt_next;

   assign mode = sdff_mode(SE, EN);

   for (genvar c = 0; c < CHAINS; c++) begin : g_seg
      sdff_scan_seg #(
         .L         (L),
         .RESET_VAL (RESET_VAL[c*L +: L])
      ) u_seg (
         .CLK  (CLK),
         .RN   (RN),
         .mode (mode),
         .d    (D[c*L +: L]),
         .si   (SI[c]),
         .so   (SO[c]),
         .q    (Q[c*L +: L])
      );
   end

   always_comb begin
      cnt_next = '0;
      if (SE) begin
         cnt_next = (SHIFT_CNT == L_CNT) ? L_CNT : SHIFT_CNT + CW'(1);
      end
   end

   // DONE is registered from the next count so it lines up with SHIFT_CNT reaching L.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         SHIFT_CNT  <= '0;
         SHIFT_DONE <= 1'b0;
      end else begin
         SHIFT_CNT  <= cnt_next;
         SHIFT_DONE <= (cnt_next == L_CNT);
      end
   end

   if (SHADOW) begin : g_shadow
      // Samples the pre-edge Q, so a capture on the same edge lands only in Q.
      always_ff @(posedge CLK or negedge RN) begin
         if (!RN) begin
            QS <= RESET_VAL;
         end else if (UPD && !SE) begin
            QS <= Q;
         end
      end
   end else begin : g_no_shadow
      assign QS = Q;
   end

endmodule

// File: tb/tb_sdff_scan_bank.sv
// Directed and random checks of a 2x4 shadowed bank and a 1-bit bank against a bit-level model.
module tb_sdff_scan_bank;

   localparam int L = 4;

   logic       clk = 1'b0;
   logic       rn, se, en, upd, si_b;
   logic [7:0] d;
   logic [1:0] si;

   logic [7:0] q_a, qs_a;
   logic [1:0] so_a;
   logic [2:0] cnt_a;
   logic       done_a;
   logic [0:0] q_b, qs_b, so_b, cnt_b;
   logic       done_b;

   int n_cmp = 0;
   int n_err = 0;

   int m_q, m_qs, m_cnt;
   bit m_done;
   bit m1_q;
   int m1_cnt;

   always #5 clk = ~clk;

   sdff_scan_bank #(.WIDTH(8), .CHAINS(2), .RESET_VAL(8'hA5), .SHADOW(1)) dut_a (
      .CLK(clk), .RN(rn), .SE(se), .EN(en), .D(d), .SI(si), .UPD(upd),
      .Q(q_a), .SO(so_a), .QS(qs_a), .SHIFT_CNT(cnt_a), .SHIFT_DONE(done_a)
   );

   sdff_scan_bank #(.WIDTH(1), .CHAINS(1), .RESET_VAL(1'b0), .SHADOW(0)) dut_b (
      .CLK(clk), .RN(rn), .SE(se), .EN(en), .D(d[0:0]), .SI(si_b), .UPD(upd),
      .Q(q_b), .SO(so_b), .QS(qs_b), .SHIFT_CNT(cnt_b), .SHIFT_DONE(done_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q = 8'hA5; m_qs = 8'hA5; m_cnt = 0; m_done = 0;
      m1_q = 0; m1_cnt = 0;
   endtask

   // Applies one clock edge's worth of the rules to the model using the current inputs.
   task automatic model_edge();
      int nq, seg;
      if (se) begin
         nq = 0;
         for (int c = 0; c < 2; c++) begin
            seg = (m_q >> (c * L)) & 15;
            seg = ((seg << 1) | int'(si[c])) & 15;
            nq  = nq | (seg << (c * L));
         end
      end else if (en) begin
         nq = int'(d);
      end else begin
         nq = m_q;
      end
      if (upd && !se) m_qs = m_q;
      m_q    = nq;
      m_cnt  = se ? ((m_cnt + 1 > L) ? L : m_cnt + 1) : 0;
      m_done = (m_cnt == L);
      if (se) m1_q = si_b;
      else if (en) m1_q = d[0];
      m1_cnt = se ? 1 : 0;
   endtask

   task automatic check_all();
      check("q_a", 32'(q_a), 32'(m_q));
      check("qs_a", 32'(qs_a), 32'(m_qs));
      check("so_a", 32'(so_a), 32'((((m_q >> 7) & 1) << 1) | ((m_q >> 3) & 1)));
      check("cnt_a", 32'(cnt_a), 32'(m_cnt));
      check("done_a", 32'(done_a), 32'(m_done));
      check("q_b", 32'(q_b), 32'(m1_q));
      check("so_b", 32'(so_b), 32'(m1_q));
      check("qs_b", 32'(qs_b), 32'(m1_q));
      check("cnt_b", 32'(cnt_b), 32'(m1_cnt));
      check("done_b", 32'(done_b), 32'(m1_cnt == 1));
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic drive(input logic s, input logic e, input logic u,
                        input logic [7:0] dd, input logic [1:0] ss);
      se = s; en = e; upd = u; d = dd; si = ss;
   endtask

   initial begin
      rn = 1'b0; si_b = 1'b0;
      drive(0, 0, 0, 8'h00, 2'b00);
      model_reset();

      // Reset held while the clock runs
      repeat (3) @(posedge clk);
      #1;
      check("rst_q", 32'(q_a), 32'h A5);
      check("rst_qs", 32'(qs_a), 32'h A5);
      check("rst_cnt", 32'(cnt_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_q_b", 32'(q_b), 32'd0);
      rn = 1'b1;

      // Capture then hold
      drive(0, 1, 0, 8'h3C, 2'b00); cyc();
      check("cap_q", 32'(q_a), 32'h3C);
      drive(0, 0, 0, 8'hFF, 2'b00); cyc();
      check("hold_q", 32'(q_a), 32'h3C);

      // Shadow update with simultaneous capture, then UPD ignored during shift
      drive(0, 1, 1, 8'h00, 2'b00); cyc();
      check("shadow_qs", 32'(qs_a), 32'h3C);
      check("shadow_q", 32'(q_a), 32'h00);
      drive(1, 0, 1, 8'h00, 2'b11); cyc();
      check("shadow_shift_qs", 32'(qs_a), 32'h3C);

      // Full shift with saturation
      drive(0, 0, 0, 8'h00, 2'b00); cyc();
      check("pre_shift_cnt", 32'(cnt_a), 32'd0);
      drive(1, 0, 0, 8'hAA, 2'b01);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         check("shift_cnt", 32'(cnt_a), 32'(i));
         check("shift_done", 32'(done_a), 32'(i == 4));
      end
      check("shift_q", 32'(q_a), 32'h0F);
      check("shift_so", 32'(so_a), 32'h1);
      cyc();
      check("sat_cnt", 32'(cnt_a), 32'd4);
      check("sat_done", 32'(done_a), 32'd1);

      // Interrupted shift
      drive(0, 0, 0, 8'h00, 2'b00); cyc();
      for (int i = 1; i <= 2; i++) begin
         drive(1, 0, 0, 8'h00, 2'($urandom)); cyc();
         check("intr_cnt_a", 32'(cnt_a), 32'(i));
         check("intr_done_a", 32'(done_a), 32'd0);
      end
      drive(0, 0, 0, 8'h00, 2'b00); cyc();
      check("intr_clear", 32'(cnt_a), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         drive(1, 0, 0, 8'h00, 2'($urandom)); cyc();
         check("intr_cnt_b", 32'(cnt_a), 32'(i));
         check("intr_done_b", 32'(done_a), 32'(i == 4));
      end

      // Asynchronous reset asserted mid-cycle takes effect before the next edge
      #3 rn = 1'b0;
      #1;
      check("arst_q", 32'(q_a), 32'h A5);
      check("arst_qs", 32'(qs_a), 32'h A5);
      check("arst_cnt", 32'(cnt_a), 32'd0);
      check("arst_done", 32'(done_a), 32'd0);
      check("arst_q_b", 32'(q_b), 32'd0);
      model_reset();
      #2 rn = 1'b1;

      // Random traffic on both banks
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 2) == 0 ? 1 : 0) | 1'($urandom_range(0, 3) == 0 ? 0 : ($urandom & 1)),
               1'($urandom), 1'($urandom), 8'($urandom), 2'($urandom));
         si_b = 1'($urandom);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
